// File: rtl/engine_plant_model.sv
// Synthesizable engine/starter plant: turns controller enable/motor drive into
// engine-running feedback, with crank time, spin-down, stall injection and grind fault.
module engine_plant_model #(
    parameter int unsigned CRANK_CYCLES    = 4,
    parameter int unsigned SPINDOWN_CYCLES = 3,
    parameter int unsigned GRIND_LIMIT     = 6,
    parameter int unsigned CW              = 8
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          enable,
    input  logic          motor,
    input  logic          stall_inj,
    output logic          sense,
    output logic          running,
    output logic          fault,
    output logic [CW-1:0] starts
);

    typedef enum logic [2:0] {
        ST_OFF,
        ST_CRANK,
        ST_RUN,
        ST_SPINDOWN,
        ST_FAULT
    } state_t;

    // 17-bit compares so cnt+1 never wraps before reaching a 65535 limit.
    localparam logic [16:0] LP_CRANK = 17'(CRANK_CYCLES);
    localparam logic [16:0] LP_GRIND = 17'(GRIND_LIMIT);
    localparam logic [15:0] LP_SPIN  = 16'(SPINDOWN_CYCLES);

    state_t        r_state;
    state_t        w_state_nxt;
    logic [15:0]   r_cnt;
    logic [15:0]   w_cnt_nxt;
    logic [CW-1:0] r_starts;
    logic [CW-1:0] w_starts_nxt;
    logic          r_sense;
    logic          r_running;
    logic          r_fault;
    logic          w_crank;
    logic          w_enter_run;
    logic [16:0]   w_cnt_inc;
    logic          w_crank_done;
    logic          w_grind_done;

    assign w_crank      = enable & motor;
    assign w_cnt_inc    = {1'b0, r_cnt} + 17'd1;
    assign w_crank_done = (w_cnt_inc == LP_CRANK);
    assign w_grind_done = (w_cnt_inc == LP_GRIND);

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_enter_run = 1'b0;
        case (r_state)
            ST_OFF: begin
                if (w_crank) begin
                    if (LP_CRANK == 17'd1) begin
                        w_state_nxt = ST_RUN;
                        w_enter_run = 1'b1;
                        w_cnt_nxt   = 16'd0;
                    end else begin
                        w_state_nxt = ST_CRANK;
                        w_cnt_nxt   = 16'd1;
                    end
                end
            end
            ST_CRANK: begin
                if (stall_inj || !w_crank) begin
                    w_state_nxt = ST_OFF;
                    w_cnt_nxt   = 16'd0;
                end else if (w_crank_done) begin
                    w_state_nxt = ST_RUN;
                    w_enter_run = 1'b1;
                    w_cnt_nxt   = 16'd0;
                end else begin
                    w_cnt_nxt = r_cnt + 16'd1;
                end
            end
            ST_RUN: begin
                // In RUN the counter tracks consecutive starter grind cycles.
                if (w_crank && w_grind_done) begin
                    w_state_nxt = ST_FAULT;
                    w_cnt_nxt   = 16'd0;
                end else if (stall_inj) begin
                    w_state_nxt = ST_OFF;
                    w_cnt_nxt   = 16'd0;
                end else if (!enable) begin
                    w_state_nxt = ST_SPINDOWN;
                    w_cnt_nxt   = 16'd1;
                end else if (w_crank) begin
                    w_cnt_nxt = r_cnt + 16'd1;
                end else begin
                    w_cnt_nxt = 16'd0;
                end
            end
            ST_SPINDOWN: begin
                if (stall_inj) begin
                    w_state_nxt = ST_OFF;
                    w_cnt_nxt   = 16'd0;
                end else if (enable) begin
                    w_state_nxt = ST_RUN;
                    w_cnt_nxt   = 16'd0;
                end else if (r_cnt == LP_SPIN) begin
                    w_state_nxt = ST_OFF;
                    w_cnt_nxt   = 16'd0;
                end else begin
                    w_cnt_nxt = r_cnt + 16'd1;
                end
            end
            ST_FAULT: begin
                w_state_nxt = ST_FAULT;
            end
            default: begin
                w_state_nxt = ST_OFF;
                w_cnt_nxt   = 16'd0;
            end
        endcase
        w_starts_nxt = (w_enter_run && (r_starts != {CW{1'b1}})) ? r_starts + CW'(1) : r_starts;
    end

    // Outputs are registered copies of the next-state decode, so they change on the same edge as the state.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state   <= ST_OFF;
            r_cnt     <= 16'd0;
            r_starts  <= '0;
            r_sense   <= 1'b0;
            r_running <= 1'b0;
            r_fault   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_starts  <= w_starts_nxt;
            r_sense   <= (w_state_nxt == ST_RUN) || (w_state_nxt == ST_SPINDOWN);
            r_running <= (w_state_nxt == ST_RUN);
            r_fault   <= (w_state_nxt == ST_FAULT);
        end
    end

    assign sense   = r_sense;
    assign running = r_running;
    assign fault   = r_fault;
    assign starts  = r_starts;

endmodule

// File: tb/tb_engine_plant_model.sv
// Directed bench for engine_plant_model: a vector table for the main sequence plus
// hand-written sequences for grind fault, priority, saturation and async reset.
module tb_engine_plant_model;

    typedef struct packed {
        logic       en;
        logic       mo;
        logic       st;
        logic       se;
        logic       ru;
        logic       fa;
        logic [7:0] starts;
    } vec_t;

    logic       clock;
    logic       reset;
    logic       enable;
    logic       motor;
    logic       stall_inj;
    logic       sense;
    logic       running;
    logic       fault;
    logic [7:0] starts;
    logic       sense2;
    logic       running2;
    logic       fault2;
    logic [1:0] starts2;

    int   n_checks;
    int   n_fail;
    vec_t vecs[$];

    engine_plant_model #(.CRANK_CYCLES(4), .SPINDOWN_CYCLES(3), .GRIND_LIMIT(6), .CW(8)) dut (
        .clock(clock), .reset(reset), .enable(enable), .motor(motor), .stall_inj(stall_inj),
        .sense(sense), .running(running), .fault(fault), .starts(starts)
    );

    engine_plant_model #(.CRANK_CYCLES(4), .SPINDOWN_CYCLES(3), .GRIND_LIMIT(6), .CW(2)) dut_sat (
        .clock(clock), .reset(reset), .enable(enable), .motor(motor), .stall_inj(stall_inj),
        .sense(sense2), .running(running2), .fault(fault2), .starts(starts2)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic en, input logic mo, input logic st);
        enable    = en;
        motor     = mo;
        stall_inj = st;
    endtask

    task automatic add(input logic en, input logic mo, input logic st,
                       input logic se, input logic ru, input logic fa, input logic [7:0] s);
        vecs.push_back({en, mo, st, se, ru, fa, s});
    endtask

    // {sense, running, fault, starts} of the main instance.
    function automatic logic [31:0] outs();
        return {21'd0, sense, running, fault, starts};
    endfunction

    function automatic logic [31:0] exp_outs(input logic se, input logic ru, input logic fa,
                                             input logic [7:0] s);
        return {21'd0, se, ru, fa, s};
    endfunction

    // Pulse reset between edges and release it before the next rising edge.
    task automatic async_reset_check(input string name);
        #1 reset = 1'b0;
        #1;
        check({name, "_main"}, outs(), 32'd0);
        check({name, "_sat"}, {28'd0, sense2, running2, fault2, starts2}, 32'd0);
        reset = 1'b1;
    endtask

    task automatic start_engine();
        drive(1, 1, 0);
        repeat (4) step();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b0;
        drive(0, 0, 0);

        // Main sequence: en mo st -> sense running fault starts
        add(1,1,0, 0,0,0,0); add(1,1,0, 0,0,0,0); add(1,1,0, 0,0,0,0); add(1,1,0, 1,1,0,1);
        add(1,0,0, 1,1,0,1);
        add(0,0,0, 1,0,0,1); add(0,0,0, 1,0,0,1); add(0,0,0, 1,0,0,1); add(0,0,0, 0,0,0,1);
        add(1,1,0, 0,0,0,1); add(1,1,0, 0,0,0,1); add(1,1,0, 0,0,0,1); add(1,0,0, 0,0,0,1);
        add(1,1,0, 0,0,0,1); add(1,1,0, 0,0,0,1); add(1,1,0, 0,0,0,1); add(1,1,0, 1,1,0,2);
        add(1,0,0, 1,1,0,2);
        add(0,0,0, 1,0,0,2); add(1,1,0, 1,1,0,2); add(1,0,0, 1,1,0,2);
        add(1,0,1, 0,0,0,2);
        add(1,1,1, 0,0,0,2); add(1,1,0, 0,0,0,2); add(1,1,0, 0,0,0,2); add(1,1,0, 1,1,0,3);
        add(1,0,0, 1,1,0,3);
        add(0,0,0, 1,0,0,3); add(0,0,1, 0,0,0,3);
        add(1,1,0, 0,0,0,3); add(1,1,1, 0,0,0,3);
        add(0,1,0, 0,0,0,3); add(1,0,0, 0,0,0,3);
        add(1,1,0, 0,0,0,3); add(1,1,0, 0,0,0,3); add(1,1,0, 0,0,0,3); add(1,1,0, 1,1,0,4);
        add(1,1,0, 1,1,0,4); add(1,1,0, 1,1,0,4); add(1,0,0, 1,1,0,4);

        #12;
        check("reset_state", outs(), 32'd0);
        reset = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].en, vecs[i].mo, vecs[i].st);
            step();
            check($sformatf("vec%0d", i), outs(),
                  exp_outs(vecs[i].se, vecs[i].ru, vecs[i].fa, vecs[i].starts));
        end

        // Grind fault: engine in RUN with cnt=0, starts=4.
        drive(1, 1, 0);
        repeat (5) step();
        check("grind_pre", outs(), exp_outs(1, 1, 0, 8'd4));
        step();
        check("grind_fault", outs(), exp_outs(0, 0, 1, 8'd4));
        for (int i = 0; i < 20; i++) begin
            drive(i[0], i[1], i[2]);
            step();
            check($sformatf("fault_hold%0d", i), outs(), exp_outs(0, 0, 1, 8'd4));
        end
        async_reset_check("fault_reset");
        drive(0, 0, 0);
        step();
        check("after_reset", outs(), 32'd0);

        // Grind limit and stall on the same edge: fault wins.
        start_engine();
        check("prio_run", outs(), exp_outs(1, 1, 0, 8'd1));
        repeat (5) step();
        drive(1, 1, 1);
        step();
        check("prio_fault", outs(), exp_outs(0, 0, 1, 8'd1));
        async_reset_check("prio_reset");
        drive(0, 0, 0);
        step();

        // Saturation on the CW=2 instance: five start/stop cycles.
        for (int k = 1; k <= 5; k++) begin
            start_engine();
            check($sformatf("sat_start%0d", k), {29'd0, sense2, starts2},
                  {29'd0, 1'b1, (k > 3) ? 2'd3 : 2'(k)});
            drive(0, 0, 0);
            repeat (4) step();
            check($sformatf("sat_off%0d", k), {29'd0, sense2, starts2},
                  {29'd0, 1'b0, (k > 3) ? 2'd3 : 2'(k)});
        end
        check("wide_count", {24'd0, starts}, 32'd5);

        // Async reset mid-crank, without a clock edge.
        drive(1, 1, 0);
        repeat (2) step();
        async_reset_check("midcrank_reset");
        step();
        check("midcrank_restart", outs(), exp_outs(0, 0, 0, 8'd0));
        repeat (3) step();
        check("midcrank_run", outs(), exp_outs(1, 1, 0, 8'd1));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
